// File: rtl/ch0re_pl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ch0re_pl_ctrl
//  Purpose  : 5-stage pipeline control: stage enables, flushes, PC select and
//             the illegal-instruction drain/halt/resume trap sequence.
//             Stall counter present only with CH0RE_PL_CTRL_PERF_CNT_EN.
//  Revision : 1.0
// ============================================================================
module ch0re_pl_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_id_valid,
    input  logic             i_id_stall,
    input  logic             i_id_illegal,
    input  logic             i_ex_redirect,
    input  logic             i_mem_busy,
    input  logic             i_resume,
    input  logic             i_cnt_clr,
    output logic             o_if_en,
    output logic             o_id_en,
    output logic             o_ex_en,
    output logic             o_mem_en,
    output logic             o_wb_en,
    output logic             o_if_flush,
    output logic             o_id_flush,
    output logic [1:0]       o_pc_sel,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int c_dcnt_w = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_dcnt_w-1:0] c_dcnt_init = c_dcnt_w'(DRAIN_CYCLES - 1);

    localparam logic [1:0] c_pc_seq   = 2'd0;
    localparam logic [1:0] c_pc_redir = 2'd1;
    localparam logic [1:0] c_pc_trap  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_dcnt_w-1:0]   r_dcnt;
    logic [c_dcnt_w-1:0]   w_dcnt_nxt;
    logic                  w_stall_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_stall_inc = 1'b0;
        o_if_en     = 1'b0;
        o_id_en     = 1'b0;
        o_ex_en     = 1'b0;
        o_mem_en    = 1'b0;
        o_wb_en     = 1'b0;
        o_if_flush  = 1'b0;
        o_id_flush  = 1'b0;
        o_pc_sel    = c_pc_seq;
        o_halted    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (i_mem_busy) begin
                    w_stall_inc = 1'b1;
                end else if (i_ex_redirect) begin
                    {o_if_en, o_id_en, o_ex_en, o_mem_en, o_wb_en} = 5'b11111;
                    {o_if_flush, o_id_flush} = 2'b11;
                    o_pc_sel = c_pc_redir;
                end else if (i_id_valid && i_id_illegal) begin
                    {o_ex_en, o_mem_en, o_wb_en} = 3'b111;
                    o_id_flush  = 1'b1;
                    w_dcnt_nxt  = c_dcnt_init;
                    w_state_nxt = ST_DRAIN;
                end else if (i_id_valid && i_id_stall) begin
                    {o_ex_en, o_mem_en, o_wb_en} = 3'b111;
                    o_id_flush  = 1'b1;
                    w_stall_inc = 1'b1;
                end else begin
                    {o_if_en, o_id_en, o_ex_en, o_mem_en, o_wb_en} = 5'b11111;
                end
            end
            ST_DRAIN: begin
                if (i_mem_busy) begin
                    // full freeze; drain count holds via the defaults
                end else if (i_ex_redirect) begin
                    // the trapping instruction was on the wrong path
                    {o_if_en, o_id_en, o_ex_en, o_mem_en, o_wb_en} = 5'b11111;
                    {o_if_flush, o_id_flush} = 2'b11;
                    o_pc_sel    = c_pc_redir;
                    w_state_nxt = ST_RUN;
                end else begin
                    {o_ex_en, o_mem_en, o_wb_en} = 3'b111;
                    o_id_flush = 1'b1;
                    if (r_dcnt == '0) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_dcnt_nxt = r_dcnt - 1'b1;
                    end
                end
            end
            ST_HALT: begin
                o_halted = 1'b1;
                if (i_resume) begin
                    o_if_en     = 1'b1;
                    o_if_flush  = 1'b1;
                    o_id_flush  = 1'b1;
                    o_pc_sel    = c_pc_trap;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (rst) begin
            {o_if_en, o_id_en, o_ex_en, o_mem_en, o_wb_en} = 5'b00000;
            {o_if_flush, o_id_flush} = 2'b11;
            o_pc_sel = c_pc_seq;
            o_halted = 1'b0;
        end
    end

`ifdef CH0RE_PL_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = rst ? '0 : r_stall_cnt;
`else
    logic w_unused;
    assign w_unused    = ^{i_cnt_clr, w_stall_inc};
    assign o_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ch0re_pl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ch0re_pl_ctrl
//  Purpose  : Scoreboard bench for ch0re_pl_ctrl with an independent
//             behavioural model of the pipeline control sequence.
//  Revision : 1.0
// ============================================================================
module tb_ch0re_pl_ctrl;

    localparam int DC = 3;
    localparam int CW = 16;
`ifdef CH0RE_PL_CTRL_PERF_CNT_EN
    localparam bit c_perf = 1'b1;
`else
    localparam bit c_perf = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_id_valid = 1'b0, i_id_stall = 1'b0, i_id_illegal = 1'b0;
    logic          i_ex_redirect = 1'b0, i_mem_busy = 1'b0, i_resume = 1'b0;
    logic          i_cnt_clr = 1'b0;
    logic          o_if_en, o_id_en, o_ex_en, o_mem_en, o_wb_en;
    logic          o_if_flush, o_id_flush, o_halted;
    logic [1:0]    o_pc_sel;
    logic [CW-1:0] o_stall_cnt;

    always #5 clk = ~clk;

    ch0re_pl_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst),
        .i_id_valid(i_id_valid), .i_id_stall(i_id_stall),
        .i_id_illegal(i_id_illegal), .i_ex_redirect(i_ex_redirect),
        .i_mem_busy(i_mem_busy), .i_resume(i_resume), .i_cnt_clr(i_cnt_clr),
        .o_if_en(o_if_en), .o_id_en(o_id_en), .o_ex_en(o_ex_en),
        .o_mem_en(o_mem_en), .o_wb_en(o_wb_en),
        .o_if_flush(o_if_flush), .o_id_flush(o_id_flush),
        .o_pc_sel(o_pc_sel), .o_halted(o_halted), .o_stall_cnt(o_stall_cnt)
    );

    // {if_en,id_en,ex_en,mem_en,wb_en,if_flush,id_flush,pc_sel[1:0],halted}
    localparam logic [9:0] c_rst   = 10'b00000_11_00_0;
    localparam logic [9:0] c_run   = 10'b11111_00_00_0;
    localparam logic [9:0] c_redir = 10'b11111_11_01_0;
    localparam logic [9:0] c_bub   = 10'b00111_01_00_0;
    localparam logic [9:0] c_frz   = 10'b00000_00_00_0;
    localparam logic [9:0] c_halt  = 10'b00000_00_00_1;
    localparam logic [9:0] c_trap  = 10'b10000_11_10_1;

    typedef struct {
        string         tag;
        logic [9:0]    ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    // model state: 0=RUN 1=DRAIN 2=HALT
    int m_state = 0;
    int m_dcnt  = 0;
    int m_cnt   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic st,
                        input logic il, input logic rd, input logic mb,
                        input logic rs, input logic cl);
        exp_t e;
        bit   inc;
        @(posedge clk);
        #1;
        rst = r; i_id_valid = v; i_id_stall = st; i_id_illegal = il;
        i_ex_redirect = rd; i_mem_busy = mb; i_resume = rs; i_cnt_clr = cl;

        inc = 1'b0;
        e.tag = tag;
        if (r) begin
            e.ctl = c_rst;
        end else if (m_state == 0) begin
            if (mb)               begin e.ctl = c_frz; inc = 1'b1; end
            else if (rd)          e.ctl = c_redir;
            else if (v && il)     e.ctl = c_bub;
            else if (v && st)     begin e.ctl = c_bub; inc = 1'b1; end
            else                  e.ctl = c_run;
        end else if (m_state == 1) begin
            if (mb)               e.ctl = c_frz;
            else if (rd)          e.ctl = c_redir;
            else                  e.ctl = c_bub;
        end else begin
            e.ctl = rs ? c_trap : c_halt;
        end
        e.cnt = (r || !c_perf) ? '0 : CW'(m_cnt);
        sb_q.push_back(e);

        @(negedge clk);
        begin
            exp_t x;
            x = sb_q.pop_front();
            check_val({x.tag, ".ctl"}, 32'({o_if_en, o_id_en, o_ex_en, o_mem_en, o_wb_en,
                                           o_if_flush, o_id_flush, o_pc_sel, o_halted}), 32'(x.ctl));
            check_val({x.tag, ".cnt"}, 32'(o_stall_cnt), 32'(x.cnt));
        end

        if (r) begin
            m_state = 0; m_dcnt = 0; m_cnt = 0;
        end else begin
            case (m_state)
                0: if (!mb && !rd && v && il) begin m_state = 1; m_dcnt = DC - 1; end
                1: if (!mb) begin
                       if (rd)               m_state = 0;
                       else if (m_dcnt == 0) m_state = 2;
                       else                  m_dcnt--;
                   end
                default: if (rs) m_state = 0;
            endcase
            if (cl)                         m_cnt = 0;
            else if (inc && m_cnt < 65535)  m_cnt++;
        end
    endtask

    //                       tag        r  v  st il rd mb rs cl
    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step("rst0", 1, 0, 0, 0, 0, 0, 0, 0);
        step("rst1", 1, 1, 1, 0, 0, 0, 0, 0);
        idle("rel");

        step("stall0", 0, 1, 1, 0, 0, 0, 0, 0);
        step("stall1", 0, 1, 1, 0, 0, 0, 0, 0);
        idle("stall_done");

        step("redir_pri", 0, 1, 1, 1, 1, 0, 0, 0);
        idle("redir_after");

        step("ill", 0, 1, 0, 1, 0, 0, 0, 0);
        idle("drain0"); idle("drain1"); idle("drain2");
        idle("halt0");
        step("halt_ign", 0, 1, 1, 1, 0, 0, 0, 0);
        step("resume", 0, 0, 0, 0, 0, 0, 1, 0);
        idle("post_res");

        step("ill_b", 0, 1, 0, 1, 0, 0, 0, 0);
        idle("drb0");
        step("drb_busy0", 0, 0, 0, 0, 0, 1, 0, 0);
        step("drb_busy1", 0, 0, 0, 0, 0, 1, 0, 0);
        idle("drb1"); idle("drb2");
        idle("halt_b");
        step("resume_b", 0, 0, 0, 0, 0, 0, 1, 0);

        step("ill_r", 0, 1, 0, 1, 0, 0, 0, 0);
        idle("drr0");
        step("drr_redir", 0, 0, 0, 0, 1, 0, 0, 0);
        idle("drr_run0"); idle("drr_run1"); idle("drr_run2");

        step("res_ign", 0, 0, 0, 0, 0, 0, 1, 0);
        step("busy_run", 0, 1, 1, 1, 1, 1, 0, 0);
        idle("busy_after");

        step("clr", 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 65534; i++) step("fill", 0, 1, 1, 0, 0, 0, 0, 0);
        idle("at_fffe");
        for (int i = 0; i < 3; i++) step("sat", 0, 1, 1, 0, 0, 0, 0, 0);
        idle("at_ffff");
        step("clr_stall", 0, 1, 1, 0, 0, 0, 0, 1);
        idle("cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
